// File: rtl/switch_debounce_reader.sv
// Debounced N-channel switch reader: 2-flop sync, per-channel debounce, masked all-closed flag.
// Optional sticky drop-out flags are enabled by defining SWREAD_DROP_LATCH_EN.
module switch_debounce_reader #(
  parameter int N_SW      = 20,
  parameter int DB_CYCLES = 50000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_SW-1:0] in,
  input  logic [N_SW-1:0] mask,
  input  logic            clr_drop,
  output logic [N_SW-1:0] sw_state,
  output logic            out,
  output logic            led,
  output logic            change,
  output logic [N_SW-1:0] drop
);

  localparam int CNT_W = ($clog2(DB_CYCLES) > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  logic [N_SW-1:0]  s1, s2, upd;
  logic [CNT_W-1:0] cnt     [N_SW];
  logic [CNT_W-1:0] cnt_nxt [N_SW];
  logic             all_closed;

  // A channel updates only after DB_CYCLES consecutive mismatching samples.
  always_comb begin
    for (int i = 0; i < N_SW; i++) begin
      upd[i]     = 1'b0;
      cnt_nxt[i] = '0;
      if (s2[i] != sw_state[i]) begin
        if (cnt[i] == CNT_MAX) upd[i] = 1'b1;
        else                   cnt_nxt[i] = cnt[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1       <= '0;
      s2       <= '0;
      sw_state <= '0;
      change   <= 1'b0;
      for (int i = 0; i < N_SW; i++) cnt[i] <= '0;
    end else begin
      s1       <= in;
      s2       <= s1;
      sw_state <= (sw_state & ~upd) | (s2 & upd);
      change   <= |(upd & mask);
      for (int i = 0; i < N_SW; i++) cnt[i] <= cnt_nxt[i];
    end
  end

  assign all_closed = (&(sw_state | ~mask)) & (|mask);
  assign out        = all_closed;
  assign led        = all_closed;

`ifdef SWREAD_DROP_LATCH_EN
  // A falling update on an enabled channel while everything was closed marks a drop-out.
  logic [N_SW-1:0] drop_set;
  assign drop_set = upd & sw_state & mask & {N_SW{all_closed}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop <= '0;
    else        drop <= (clr_drop ? '0 : drop) | drop_set;
  end
`else
  logic unused_clr_drop;
  assign unused_clr_drop = clr_drop;
  assign drop            = '0;
`endif

endmodule

// File: tb/tb_switch_debounce_reader.sv
// Self-checking bench for switch_debounce_reader: directed plan steps plus random toggling
// checked every cycle against a run-length reference model.
module tb_switch_debounce_reader;

  localparam int N  = 20;
  localparam int DB = 4;
  localparam logic [N-1:0] ALL = '1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clr_drop = 1'b0;
  logic [N-1:0] in_v = '1;
  logic [N-1:0] mask_v = '1;
  logic [N-1:0] sw_state, drop;
  logic         out, led, change;

  int n_assert = 0;
  int n_fail   = 0;

  // reference model state
  logic [N-1:0] m_s1, m_s2, m_st, m_drop;
  logic         m_chg;
  int           m_run [N];

  always #5 clk = ~clk;

  switch_debounce_reader #(.N_SW(N), .DB_CYCLES(DB)) dut (
    .clk(clk), .rst_n(rst_n), .in(in_v), .mask(mask_v), .clr_drop(clr_drop),
    .sw_state(sw_state), .out(out), .led(led), .change(change), .drop(drop)
  );

  function automatic logic m_out();
    return (&(m_st | ~mask_v)) && (|mask_v);
  endfunction

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("sw_state", sw_state, m_st);
    check("out", N'(out), N'(m_out()));
    check("led", N'(led), N'(m_out()));
    check("change", N'(change), N'(m_chg));
    check("drop", drop, m_drop);
  endtask

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_st = '0; m_drop = '0; m_chg = 1'b0;
    for (int i = 0; i < N; i++) m_run[i] = 0;
  endtask

  // One clock edge: a channel flips once its synchronised input has disagreed for DB edges in a row.
  task automatic model_edge();
    logic [N-1:0] flip;
    logic         was_closed;
    if (!rst_n) return;
    flip = '0;
    for (int i = 0; i < N; i++) begin
      if (m_s2[i] != m_st[i]) begin
        m_run[i]++;
        if (m_run[i] == DB) begin
          flip[i]  = 1'b1;
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    was_closed = m_out();
`ifdef SWREAD_DROP_LATCH_EN
    m_drop = (clr_drop ? '0 : m_drop) | (flip & m_st & mask_v & {N{was_closed}});
`endif
    m_st  = m_st ^ flip;
    m_chg = |(flip & mask_v);
    m_s2  = m_s1;
    m_s1  = in_v;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    int b;
    model_reset();
    #2;
    check_all();
    check("reset_sw", sw_state, '0);

    // power-up with all switches closed
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) step();
    check("pre_edge6_sw", sw_state, '0);
    step();
    check("edge6_sw", sw_state, ALL);
    check("edge6_out", N'(out), N'(1'b1));
    check("edge6_change", N'(change), N'(1'b1));
    step();
    check("edge7_change", N'(change), N'(1'b0));

    // 3-cycle glitch on channel 7 is rejected
    in_v[7] = 1'b0;
    repeat (3) step();
    in_v[7] = 1'b1;
    repeat (8) step();
    check("glitch_sw", sw_state, ALL);
    check("glitch_out", N'(out), N'(1'b1));

    // held open on channel 7
    in_v[7] = 1'b0;
    repeat (5) step();
    check("hold_pre_sw", sw_state, ALL);
    step();
    check("hold_sw", sw_state, ALL ^ N'(20'h00080));
    check("hold_out", N'(out), N'(1'b0));
    check("hold_change", N'(change), N'(1'b1));
    step();

    // masking
    mask_v = 20'hFFF7F;
    #1;
    check("mask_out", N'(out), N'(1'b1));
    check("mask_led", N'(led), N'(1'b1));
    step();
    check("mask_change", N'(change), N'(1'b0));
    mask_v = '0;
    #1;
    check("mask0_out", N'(out), N'(1'b0));
    step();

    // reset in the middle of a debounce count
    mask_v  = ALL;
    in_v[7] = 1'b1;
    repeat (4) step();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    check("midrst_sw", sw_state, '0);
    check("midrst_out", N'(out), N'(1'b0));
    repeat (2) step();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) step();
    check("rst_pre_sw", sw_state, '0);
    step();
    check("rst_edge6_sw", sw_state, ALL);
    check("rst_edge6_out", N'(out), N'(1'b1));
    step();

`ifdef SWREAD_DROP_LATCH_EN
    in_v[3] = 1'b0;
    repeat (6) step();
    in_v[3] = 1'b1;
    repeat (8) step();
    check("drop3", drop, N'(20'h00008));
    in_v[5] = 1'b0;
    repeat (5) step();
    clr_drop = 1'b1;
    step();
    clr_drop = 1'b0;
    check("drop5_setwins", drop, N'(20'h00020));
    in_v[5] = 1'b1;
    repeat (8) step();
`endif

    // random toggling, masks and clears
    repeat (600) begin
      if ($urandom_range(0, 5) == 0) begin
        b = int'($urandom_range(0, N - 1));
        in_v[b] = ~in_v[b];
      end
      if ($urandom_range(0, 39) == 0)
        mask_v = ($urandom_range(0, 1) == 1) ? ALL : N'($urandom);
      clr_drop = ($urandom_range(0, 15) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
